gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq: RTL

//  Parametrised, sequenced successor to the passive fill cells. Steps NUM_BANKS switchable fill/decap banks
//  on one at a time, then off in reverse order, with a programmable dwell between steps to limit inrush.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq_pkg.sv | 12 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__fill_bank_pick.sv | 37 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq_pkg.sv
// Shared types for the sequenced fill/decap bank controller.
// State encodings match the power controller's view: OFF=0, RAMP_UP=1, ON=2, RAMP_DN=3.
package gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq_pkg;

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_RAMP_UP = 2'd1,
    S_ON      = 2'd2,
    S_RAMP_DN = 2'd3
  } fbs_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fill_bank_pick.sv
// Combinational bank selector: next masked bank to enable, highest enabled bank to drop,
// and whether that step completes the ramp (last) or empties the bank set (empty).
module gf180mcu_fd_sc_mcu7t5v0__fill_bank_pick #(
  parameter int NUM_BANKS = 8
) (
  input  logic [NUM_BANKS-1:0] mask,
  input  logic [NUM_BANKS-1:0] bank_en,
  output logic [NUM_BANKS-1:0] set_oh,
  output logic [NUM_BANKS-1:0] clr_oh,
  output logic                 last,
  output logic                 empty
);

  logic [NUM_BANKS-1:0] free;

  // Enabled banks are always the lowest masked ones, so the next one is the lowest free bit.
  always_comb begin
    free   = mask & ~bank_en;
    set_oh = free & (~free + {{(NUM_BANKS-1){1'b0}}, 1'b1});
  end

  always_comb begin
    clr_oh = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_en[i]) begin
        clr_oh    = '0;
        clr_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    last  = ((bank_en | set_oh) == mask);
    empty = ((bank_en & ~clr_oh) == '0);
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq.sv
// Sequenced fill/decap bank switch: banks step on low-to-high and off high-to-low,
// STEP+1 cycles apart, to bound inrush when the domain controller toggles EN.
module gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq
  import gf180mcu_fd_sc_mcu7t5v0__fill_bank_seq_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                  VDD,
  inout  wire                  VSS,
`endif
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [CNT_W-1:0]     STEP,
  input  logic [NUM_BANKS-1:0] MASK,
  output logic [NUM_BANKS-1:0] BANK_EN,
  output logic                 READY,
  output logic                 IDLE,
  output logic                 BUSY
);

  fbs_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;

  logic [NUM_BANKS-1:0] pick_mask, set_oh, clr_oh;
  logic                 last, empty;

  // In OFF the live MASK input is what gets captured, so the picker looks at it directly.
  assign pick_mask = (state_q == S_OFF) ? MASK : mask_q;

  gf180mcu_fd_sc_mcu7t5v0__fill_bank_pick #(.NUM_BANKS(NUM_BANKS)) u_pick (
    .mask    (pick_mask),
    .bank_en (bank_en_q),
    .set_oh  (set_oh),
    .clr_oh  (clr_oh),
    .last    (last),
    .empty   (empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    bank_en_d = bank_en_q;
    case (state_q)
      S_OFF: begin
        if (EN) begin
          mask_d    = MASK;
          cnt_d     = STEP;
          bank_en_d = set_oh;
          state_d   = last ? S_ON : S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (!EN) begin
          bank_en_d = bank_en_q & ~clr_oh;
          cnt_d     = STEP;
          state_d   = empty ? S_OFF : S_RAMP_DN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          bank_en_d = bank_en_q | set_oh;
          cnt_d     = STEP;
          if (last) state_d = S_ON;
        end
      end
      S_ON: begin
        if (!EN) begin
          // An empty captured mask has nothing to ramp down.
          if (bank_en_q == '0) begin
            state_d = S_OFF;
          end else begin
            bank_en_d = bank_en_q & ~clr_oh;
            cnt_d     = STEP;
            state_d   = empty ? S_OFF : S_RAMP_DN;
          end
        end
      end
      S_RAMP_DN: begin
        if (EN) begin
          bank_en_d = bank_en_q | set_oh;
          cnt_d     = STEP;
          state_d   = last ? S_ON : S_RAMP_UP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          bank_en_d = bank_en_q & ~clr_oh;
          cnt_d     = STEP;
          if (empty) state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Async reset drops every bank at once, even mid-ramp.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      mask_q    <= '0;
      bank_en_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      bank_en_q <= bank_en_d;
    end
  end

  assign BANK_EN = bank_en_q;
  assign READY   = (state_q == S_ON);
  assign IDLE    = (state_q == S_OFF);
  assign BUSY    = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DN);

`ifndef FUNCTIONAL
  specify
  endspecify
`endif

endmodule
